// File: rtl/mem_copy_master.sv
// Bus initiator that copies a block of 32-bit words from a source range to a
// destination range, one read/write pair at a time over a valid/ready bus.
module mem_copy_master #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [31:0]      addr_o,
    output logic [31:0]      data_o,
    output logic [3:0]       sel_o,
    output logic             we_o,
    input  logic [31:0]      data_i,
    output logic             req_valid_o,
    input  logic             req_ready_i,
    input  logic             rsp_valid_i,
    output logic             rsp_ready_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_REQ = 3'd1,
        RD_RSP = 3'd2,
        WR_REQ = 3'd3,
        WR_RSP = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t             state_q,     state_d;
    logic [31:0]        src_q,       src_d;
    logic [31:0]        dst_q,       dst_d;
    logic [LEN_W-1:0]   cnt_q,       cnt_d;
    logic [31:0]        rdata_q,     rdata_d;

    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    logic [31:0]        addr_q,      addr_d;
    logic [31:0]        wdata_q,     wdata_d;
    logic [3:0]         sel_q,       sel_d;
    logic               we_q,        we_d;
    logic               req_valid_q, req_valid_d;
    logic               rsp_ready_q, rsp_ready_d;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        src_d   = src_addr_i & 32'hFFFF_FFFC;
                        dst_d   = dst_addr_i & 32'hFFFF_FFFC;
                        cnt_d   = len_i;
                        state_d = RD_REQ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RD_REQ: begin
                if (req_ready_i) state_d = RD_RSP;
            end
            RD_RSP: begin
                if (rsp_valid_i) begin
                    rdata_d = data_i;
                    state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                if (req_ready_i) state_d = WR_RSP;
            end
            WR_RSP: begin
                // Addresses wrap modulo 2^32; the last word ends the transfer.
                if (rsp_valid_i) begin
                    src_d   = src_q + 32'd4;
                    dst_d   = dst_q + 32'd4;
                    cnt_d   = cnt_q - LEN_W'(1);
                    state_d = (cnt_q == LEN_W'(1)) ? DONE : RD_REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they appear registered and
    // hold steady for as long as the FSM stays in a request state.
    always_comb begin
        busy_d      = 1'b0;
        done_d      = 1'b0;
        addr_d      = 32'h0;
        wdata_d     = 32'h0;
        sel_d       = 4'h0;
        we_d        = 1'b0;
        req_valid_d = 1'b0;
        rsp_ready_d = 1'b0;

        unique case (state_d)
            RD_REQ: begin
                busy_d      = 1'b1;
                req_valid_d = 1'b1;
                addr_d      = src_d;
            end
            RD_RSP: begin
                busy_d      = 1'b1;
                rsp_ready_d = 1'b1;
            end
            WR_REQ: begin
                busy_d      = 1'b1;
                req_valid_d = 1'b1;
                we_d        = 1'b1;
                sel_d       = 4'hF;
                addr_d      = dst_d;
                wdata_d     = rdata_d;
            end
            WR_RSP: begin
                busy_d      = 1'b1;
                rsp_ready_d = 1'b1;
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            src_q       <= 32'h0;
            dst_q       <= 32'h0;
            cnt_q       <= '0;
            rdata_q     <= 32'h0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            sel_q       <= 4'h0;
            we_q        <= 1'b0;
            req_valid_q <= 1'b0;
            rsp_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            req_valid_q <= req_valid_d;
            rsp_ready_q <= rsp_ready_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign addr_o      = addr_q;
    assign data_o      = wdata_q;
    assign sel_o       = sel_q;
    assign we_o        = we_q;
    assign req_valid_o = req_valid_q;
    assign rsp_ready_o = rsp_ready_q;

endmodule

// File: doc/mem_copy_master.md
Name: mem_copy_master

Overview:
- Bus initiator (DMA-lite) that copies a block of 32-bit words from a source address range to a destination address range.
- Drives the same req/rsp valid-ready memory interface that the ROM/RAM peripherals respond on; sits as an extra master port on the bus.
- Started by a single-cycle start pulse from a control register block.
- Reports completion with busy and done status.

Parameters:
- LEN_W, 16, width of the word-count input; maximum transfer is 2^LEN_W-1 words.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low
- start_i  input  1  start pulse; sampled only in IDLE
- src_addr_i  input  32  source byte address; bits[1:0] ignored and treated as 0
- dst_addr_i  input  32  destination byte address; bits[1:0] ignored and treated as 0
- len_i  input  LEN_W  number of words to copy
- busy_o  output  1  high while a transfer is in progress
- done_o  output  1  one-cycle completion pulse
- addr_o  output  32  bus address, word aligned
- data_o  output  32  bus write data
- sel_o  output  4  byte enables; 4'hF on writes, 4'h0 on reads
- we_o  output  1  1 = write, 0 = read
- data_i  input  32  bus read data; valid only when rsp_valid_i=1
- req_valid_o  output  1  request valid
- req_ready_i  input  1  responder accepts the request
- rsp_valid_i  input  1  response valid
- rsp_ready_o  output  1  initiator accepts the response

Behaviour:
- Reset: state IDLE; all outputs 0; internal address and count registers 0.
- Request handshake: a request transfers on a cycle with req_valid_o & req_ready_i.
- Response handshake: a response transfers on a cycle with rsp_valid_i & rsp_ready_o.
- At most one outstanding transaction at any time.
- While req_valid_o=1 and the request is not yet accepted, addr_o, data_o, sel_o and we_o hold stable. req_valid_o never drops before acceptance.
- rsp_ready_o=1 only in RD_RSP and WR_RSP. rsp_valid_i in any other state is ignored.
- data_i is captured into the internal data register on the read response handshake.
- FSM states:
  - IDLE: busy_o=0. If start_i=1 and len_i!=0: latch src/dst (low bits cleared) and len, go to RD_REQ. If start_i=1 and len_i==0: go to DONE with no bus traffic. Otherwise stay.
  - RD_REQ: req_valid_o=1, we_o=0, addr_o=src. Go to RD_RSP on request handshake.
  - RD_RSP: wait for response handshake; capture data_i; go to WR_REQ.
  - WR_REQ: req_valid_o=1, we_o=1, sel_o=4'hF, addr_o=dst, data_o=captured word. Go to WR_RSP on request handshake.
  - WR_RSP: on response handshake: src+=4, dst+=4 (modulo 2^32, wraps silently), count-=1. If the count becomes 0 go to DONE, else go to RD_REQ.
  - DONE: done_o=1 for exactly one cycle, busy_o=0; go to IDLE.
- busy_o=1 in RD_REQ, RD_RSP, WR_REQ and WR_RSP.
- start_i is ignored in every state other than IDLE. Inputs src/dst/len may change freely after the start cycle.
- Latency with a zero-wait responder (req_ready_i=1, rsp_valid_i one cycle after acceptance):
  - 4 cycles per word.
  - start sampled at edge k -> done_o high in cycle k+4N+1.
  - len=0 -> done_o high in cycle k+1.
- Backpressure:
  - Arbitrary req_ready_i low cycles stall in the REQ states.
  - Arbitrary response delay stalls in the RSP states.
  - There is no timeout.
- Reset mid-transfer: immediate return to IDLE, all outputs 0. A transaction in flight is abandoned and no done pulse is generated.
- Overlapping src/dst ranges: copy proceeds strictly in ascending word order. No overlap correction.

Test Plan:
- Zero-wait responder, src=0x0000_0100, dst=0x1000_0000, len=4, source words 0xA0..0xA3 -> destination holds 0xA0..0xA3; done_o at start+17 for one cycle; busy_o high for 16 cycles.
- len=0 start -> done_o one cycle later; req_valid_o never asserted.
- req_ready_i held low 5 cycles on each request, responses delayed 3 cycles -> addr_o/data_o/we_o stable throughout each stall; copy correct; no double-issued requests.
- src=0xFFFF_FFFC, len=2 -> read addresses 0xFFFF_FFFC then 0x0000_0000 (wrap).
- src=0x103 -> first read address 0x100.
- Extra start_i pulses while busy -> ignored; exactly one done_o per accepted start.
- rst_n asserted during WR_REQ of word 2 of 4 -> all outputs 0 asynchronously; FSM in IDLE; no done_o. A new start after reset performs a full, correct copy.
